// File: rtl/mux_arb_nx1_pkg.sv
// Shared definitions for the N-to-1 registered mux/arbiter slice.
package mux_pkg;

   localparam int MUX_N_DEF = 8;
   localparam int MUX_W_DEF = 32;

   // Drive value for rr_mode: fixed external select or round-robin.
   typedef enum logic {
      MUX_FIXED = 1'b0,
      MUX_RR    = 1'b1
   } mux_mode_e;

endpackage

// File: rtl/mux_arb_nx1_if.sv
// Channel bundle between producers, the selection stage and the consumer.
// slave  : the mux/arbiter side.
// master : the environment (producers plus consumer).
interface mux_arb_nx1_if
   import mux_pkg::*;
#(
   parameter int N = MUX_N_DEF,
   parameter int W = MUX_W_DEF
) ();

   localparam int SW = $clog2(N);

   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_ready;
   logic [SW-1:0]  sel;
   logic           rr_mode;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [SW-1:0]  out_ch;
   logic           out_ready;

   modport slave (
      input  in_valid, in_data, sel, rr_mode, out_ready,
      output in_ready, out_valid, out_data, out_ch
   );

   modport master (
      output in_valid, in_data, sel, rr_mode, out_ready,
      input  in_ready, out_valid, out_data, out_ch
   );

endinterface

// File: rtl/mux_arb_nx1_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted channel
// and wraps. The pointer moves only when the caller reports a transfer.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int N  = MUX_N_DEF,
   localparam int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [SW-1:0] gnt_idx,
   output logic          gnt_valid
);

   logic [SW-1:0] r_last;
   logic [SW-1:0] w_dist [N];
   logic [SW-1:0] w_best;

   // Distance of each channel from the search start (last+1), modulo N.
   for (genvar gi = 0; gi < N; gi++) begin : g_dist
      int w_d;
      // Wrap negative distances back into 0..N-1.
      always_comb begin
         w_d = gi - int'(r_last) - 1;
         if (w_d < 0) begin
            w_d = w_d + N;
         end
         w_dist[gi] = SW'(w_d);
      end
   end

   // Smallest distance among requesting channels wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      w_best    = '0;
      for (int j = 0; j < N; j++) begin
         if (req[j] && (!gnt_valid || (w_dist[j] < w_best))) begin
            gnt_valid = 1'b1;
            gnt_idx   = SW'(j);
            w_best    = w_dist[j];
         end
      end
   end

   // Pointer reset to N-1 so channel 0 is first in line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= SW'(N - 1);
      end else if (advance) begin
         r_last <= gnt_idx;
      end
   end

endmodule

// File: rtl/mux_arb_nx1.sv
// N-channel, W-bit registered multiplexer with valid/ready on every channel.
// Optional round-robin arbitration is compiled in with MUX_ARB_RR_EN;
// without it rr_mode is ignored and the external select is always used.
module mux_arb_nx1
   import mux_pkg::*;
#(
   parameter  int N  = MUX_N_DEF,
   parameter  int W  = MUX_W_DEF,
   localparam int SW = $clog2(N)
) (
   input logic           clk,
   input logic           rst_n,
   mux_arb_nx1_if.slave  bus
);

   localparam int NP = 1 << SW;

   logic [NP-1:0] w_valid_pad;
   logic [W-1:0]  w_chan [NP];
   logic          w_load;
   logic          w_fix_valid;
   logic          w_gnt_valid;
   logic [SW-1:0] w_gnt_idx;
   logic          w_xfer;
   logic [N-1:0]  w_ready;

   logic          r_out_valid;
   logic [W-1:0]  r_out_data;
   logic [SW-1:0] r_out_ch;

   // Pad channels up to a power of two so any select value indexes safely.
   for (genvar gi = 0; gi < NP; gi++) begin : g_pad
      if (gi < N) begin : g_real
         assign w_valid_pad[gi] = bus.in_valid[gi];
         assign w_chan[gi]      = bus.in_data[gi*W +: W];
      end else begin : g_void
         assign w_valid_pad[gi] = 1'b0;
         assign w_chan[gi]      = '0;
      end
   end

   assign w_load      = !r_out_valid || bus.out_ready;
   assign w_fix_valid = ({1'b0, bus.sel} < (SW+1)'(N)) && w_valid_pad[bus.sel];

`ifdef MUX_ARB_RR_EN
   logic          w_rr_active;
   logic [SW-1:0] w_rr_idx;
   logic          w_rr_valid;
   logic          w_rr_adv;

   assign w_rr_active = (bus.rr_mode == MUX_RR);
   assign w_rr_adv    = w_load && w_rr_active && w_rr_valid && rst_n;
   assign w_gnt_idx   = w_rr_active ? w_rr_idx   : bus.sel;
   assign w_gnt_valid = w_rr_active ? w_rr_valid : w_fix_valid;

   rr_arbiter #(.N(N)) u_rr_arbiter (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (bus.in_valid),
      .advance   (w_rr_adv),
      .gnt_idx   (w_rr_idx),
      .gnt_valid (w_rr_valid)
   );
`else
   logic w_unused_rr_mode;

   assign w_unused_rr_mode = bus.rr_mode;
   assign w_gnt_idx        = bus.sel;
   assign w_gnt_valid      = w_fix_valid;
`endif

   assign w_xfer = w_load && w_gnt_valid;

   // One-hot ready toward the granted channel; silenced while in reset.
   for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign w_ready[gi] = w_xfer && rst_n && (w_gnt_idx == SW'(gi));
   end
   assign bus.in_ready = w_ready;

   // Output stage: load on transfer, drop valid when drained with no grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
      end else if (w_load) begin
         r_out_valid <= w_gnt_valid;
         if (w_gnt_valid) begin
            r_out_data <= w_chan[w_gnt_idx];
            r_out_ch   <= w_gnt_idx;
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_ch    = r_out_ch;

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Directed bench for mux_arb_nx1: N=8/W=32 and N=5/W=8 instances.
// Round-robin sequences run only when MUX_ARB_RR_EN is defined.
module tb_mux_arb_nx1;
   import mux_pkg::*;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   mux_arb_nx1_if #(.N(8), .W(32)) b8 ();
   mux_arb_nx1_if #(.N(5), .W(8))  b5 ();

   mux_arb_nx1 #(.N(8), .W(32)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
   mux_arb_nx1 #(.N(5), .W(8))  dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  sel;
      logic [7:0]  in_valid;
      logic        out_ready;
      logic [7:0]  exp_ready;
      logic        exp_ov;
      logic [31:0] exp_data;
      logic [2:0]  exp_ch;
   } vec_t;

   vec_t tbl [8];

   function automatic logic [31:0] chan8(input int i);
      return (i == 5) ? 32'hDEADBEEF : (32'hC0DE_0000 + 32'(i));
   endfunction

   function automatic logic [7:0] chan5(input int i);
      return 8'hA0 + 8'(i);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end else begin
         n_pass++;
         $display("ok   %s: %0h", nm, act);
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_pass  = 0;
      n_total = 0;

      tbl[0] = '{3'd5, 8'hFF, 1'b1, 8'h20, 1'b1, 32'hDEADBEEF, 3'd5};
      tbl[1] = '{3'd3, 8'hF7, 1'b1, 8'h00, 1'b0, 32'hDEADBEEF, 3'd5};
      tbl[2] = '{3'd0, 8'h01, 1'b0, 8'h01, 1'b1, 32'hC0DE0000, 3'd0};
      tbl[3] = '{3'd1, 8'hFF, 1'b0, 8'h00, 1'b1, 32'hC0DE0000, 3'd0};
      tbl[4] = '{3'd1, 8'hFF, 1'b1, 8'h02, 1'b1, 32'hC0DE0001, 3'd1};
      tbl[5] = '{3'd7, 8'h80, 1'b1, 8'h80, 1'b1, 32'hC0DE0007, 3'd7};
      tbl[6] = '{3'd2, 8'h04, 1'b0, 8'h00, 1'b1, 32'hC0DE0007, 3'd7};
      tbl[7] = '{3'd2, 8'h00, 1'b1, 8'h00, 1'b0, 32'hC0DE0007, 3'd7};

      rst_n        = 1'b0;
      b8.in_valid  = '0;
      b8.sel       = '0;
      b8.rr_mode   = MUX_FIXED;
      b8.out_ready = 1'b0;
      b5.in_valid  = '0;
      b5.sel       = '0;
      b5.rr_mode   = MUX_FIXED;
      b5.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) b8.in_data[i*32 +: 32] = chan8(i);
      for (int i = 0; i < 5; i++) b5.in_data[i*8 +: 8]   = chan5(i);

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("reset_out_valid", 64'(b8.out_valid), 64'd0);
      chk("reset_out_data",  64'(b8.out_data),  64'd0);
      chk("reset_out_ch",    64'(b8.out_ch),    64'd0);
      chk("reset5_out_valid", 64'(b5.out_valid), 64'd0);

      // Fixed-mode table.
      for (int i = 0; i < 8; i++) begin
         b8.sel       = tbl[i].sel;
         b8.in_valid  = tbl[i].in_valid;
         b8.out_ready = tbl[i].out_ready;
         b8.rr_mode   = MUX_FIXED;
         #1;
         chk($sformatf("vec%0d_in_ready", i), 64'(b8.in_ready), 64'(tbl[i].exp_ready));
         @(negedge clk);
         chk($sformatf("vec%0d_out_valid", i), 64'(b8.out_valid), 64'(tbl[i].exp_ov));
         chk($sformatf("vec%0d_out_data", i),  64'(b8.out_data),  64'(tbl[i].exp_data));
         chk($sformatf("vec%0d_out_ch", i),    64'(b8.out_ch),    64'(tbl[i].exp_ch));
      end

      // Reset asserted mid-stream while holding a word.
      b8.sel       = 3'd5;
      b8.in_valid  = 8'hFF;
      b8.out_ready = 1'b0;
      @(negedge clk);
      chk("pre_reset_out_valid", 64'(b8.out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(b8.out_valid), 64'd0);
      chk("midrst_out_data",  64'(b8.out_data),  64'd0);
      chk("midrst_out_ch",    64'(b8.out_ch),    64'd0);
      chk("midrst_in_ready",  64'(b8.in_ready),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef MUX_ARB_RR_EN
      // First round-robin grant after reset goes to channel 0.
      b8.rr_mode   = MUX_RR;
      b8.in_valid  = 8'hFF;
      b8.out_ready = 1'b1;
      #1;
      chk("rr_first_in_ready", 64'(b8.in_ready), 64'h01);
      @(negedge clk);
      chk("rr_first_out_ch", 64'(b8.out_ch), 64'd0);

      // Sparse requests 1010_0101: grants 0,2,5,7,0,2 back to back.
      pulse_reset();
      begin
         int exp_seq [6];
         exp_seq = '{0, 2, 5, 7, 0, 2};
         b8.in_valid = 8'b1010_0101;
         for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr%0d_in_ready", k), 64'(b8.in_ready), 64'(8'h01 << exp_seq[k]));
            @(negedge clk);
            chk($sformatf("rr%0d_out_ch", k),    64'(b8.out_ch),    64'(exp_seq[k]));
            chk($sformatf("rr%0d_out_valid", k), 64'(b8.out_valid), 64'd1);
            chk($sformatf("rr%0d_out_data", k),  64'(b8.out_data),  64'(chan8(exp_seq[k])));
         end
      end

      // Backpressure holding channel 2's word.
      b8.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("bp%0d_in_ready", k), 64'(b8.in_ready), 64'd0);
         @(negedge clk);
         chk($sformatf("bp%0d_out_ch", k),   64'(b8.out_ch),   64'd2);
         chk($sformatf("bp%0d_out_data", k), 64'(b8.out_data), 64'(chan8(2)));
      end
      b8.out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", 64'(b8.in_ready), 64'h20);
      @(negedge clk);
      chk("bp_release_out_ch", 64'(b8.out_ch), 64'd5);
`else
      // Without the arbiter rr_mode is ignored and sel still steers.
      b8.rr_mode   = MUX_RR;
      b8.sel       = 3'd4;
      b8.in_valid  = 8'hFF;
      b8.out_ready = 1'b1;
      #1;
      chk("rr_ignored_in_ready", 64'(b8.in_ready), 64'h10);
      @(negedge clk);
      chk("rr_ignored_out_ch", 64'(b8.out_ch), 64'd4);
`endif
      b8.in_valid = '0;

      // N=5: out-of-range select never grants.
      b5.rr_mode   = MUX_FIXED;
      b5.sel       = 3'd6;
      b5.in_valid  = 5'h1F;
      b5.out_ready = 1'b1;
      #1;
      chk("n5_sel6_in_ready", 64'(b5.in_ready), 64'd0);
      @(negedge clk);
      chk("n5_sel6_out_valid", 64'(b5.out_valid), 64'd0);
      b5.sel = 3'd4;
      #1;
      chk("n5_sel4_in_ready", 64'(b5.in_ready), 64'h10);
      @(negedge clk);
      chk("n5_sel4_out_ch",   64'(b5.out_ch),   64'd4);
      chk("n5_sel4_out_data", 64'(b5.out_data), 64'(chan5(4)));

`ifdef MUX_ARB_RR_EN
      // N=5 round-robin wraps 0,1,2,3,4,0.
      pulse_reset();
      b5.rr_mode = MUX_RR;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk($sformatf("n5rr%0d_in_ready", k), 64'(b5.in_ready), 64'(5'h01 << (k % 5)));
         @(negedge clk);
         chk($sformatf("n5rr%0d_out_ch", k), 64'(b5.out_ch), 64'(k % 5));
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
